pwm_register_bank: RTL and testbench
====================================

# pwm_register_bank

Register-file and PWM-generation stage directly downstream of the SPI peripheral. It accepts decoded register writes (address plus data) over a valid/ready handshake and holds the output-enable, PWM-mode and duty registers. It drives 16 output pins as static-low, static-high or a shared PWM waveform. Duty updates are shadowed and committed only at a PWM period boundary, so the waveform never glitches.

## Interface
- `CLK_DIV`, default 12: prescaler ratio; one PWM count step every `CLK_DIV` clk cycles; PWM period = 256·`CLK_DIV` cycles. Legal range 1..4095.
- `MAX_ADDR`, default 4: highest valid register address.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `wr_valid`  in  1  write request from SPI stage.
- `wr_addr`  in  7  register address.
- `wr_data`  in  8  write data.
- `wr_ready`  out  1  bank can accept a write.
- `out_lo`  out  8  output pins 7..0, registered.
- `out_hi`  out  8  output pins 15..8, registered.
- `err_addr`  out  1  one-cycle pulse: an accepted write had address > `MAX_ADDR`.

## Operation
- Registers:
  - 0x00 `en_lo`, 0x01 `en_hi`, 0x02 `mode_lo`, 0x03 `mode_hi`: each 8 bits, written immediately on accept.
  - 0x04 `duty`: written into `duty_shadow`; sets `pend`.
- Accept occurs when `wr_valid && wr_ready`. `wr_ready = !pend`, and it depends only on state, never on `wr_valid`. All addresses stall while a duty commit is pending, which preserves write ordering.
- Address > `MAX_ADDR`: no register changes, `pend` unaffected, `err_addr` = 1 for exactly the next cycle.
- Prescaler `pre` counts 0..`CLK_DIV`-1. `tick` is asserted when `pre == CLK_DIV-1`; `pre` then wraps to 0.
- PWM counter `cnt` (8 bit) increments on `tick`, wraps 255→0. Boundary `wrap` = `tick && cnt == 255`.
- At `wrap`, if `pend` was already 1 before this cycle: `duty_active <= duty_shadow`, `pend <= 0`.
- A duty write accepted in the same cycle as `wrap` is not committed then. It commits at the following boundary.
- `pwm_sig`:
  - 1 when `duty_active == 255`;
  - otherwise 1 when `cnt < duty_active`.
  - `duty_active == 0` therefore gives constant 0.
- Pin i: `en[i] ? (mode[i] ? pwm_sig : 1) : 0`.
- Pin values are registered into `out_lo` and `out_hi`.
- Unsigned arithmetic throughout. No saturation is needed beyond the 255 special case.

## Timing
- Reset values:
  - all registers, `duty_shadow`, `duty_active`, `pend`, `pre`, `cnt` = 0;
  - `out_lo`, `out_hi` = 0x00; `err_addr` = 0;
  - `wr_ready` = 1.
- Write to 0x00–0x03 accepted at edge N: register visible after edge N; pins reflect it after edge N+1 (2-edge latency).
- `err_addr` high for the cycle following the accepting edge.
- Duty write: `wr_ready` falls after the accepting edge. It stays low until the commit edge, at most one PWM period plus one cycle. `wr_ready` rises after that same commit edge.
- New duty takes effect from `cnt == 0` of the period following the commit. Pins show it one edge later.
- Asynchronous reset mid-period or mid-pend:
  - all state clears immediately and pins go 0;
  - a pending duty is discarded;
  - counting restarts at `pre = cnt = 0` after release.
- `CLK_DIV == 1`: `tick` is constant 1.

## Structure
- Shared package `pwm_pkg`:
  - address constants `ADDR_EN_LO`, `ADDR_EN_HI`, `ADDR_MODE_LO`, `ADDR_MODE_HI`, `ADDR_DUTY`;
  - `MAX_ADDR`; `DUTY_W` = 8.
  - These constants are also used by the SPI stage.
- Sub-module `pwm_counter`: prescaler, 8-bit counter, `tick`, `wrap` and `pwm_sig` generation from a `duty_active` input.
- The top level holds the register file, shadow/pend logic, handshake, error pulse and output mux/registers.

## Test plan
- Reset: assert `rst_n` low mid-run → pins 0x00/0x00, `wr_ready` = 1, `err_addr` = 0 immediately; still so 10 cycles after release.
- Static drive: write 0x00=0xA5, 0x02=0x00 → `out_lo` = 0xA5 two edges after accept; `out_hi` stays 0x00.
- PWM duty (`CLK_DIV`=2): write en_hi=0xFF, mode_hi=0xFF, duty=0x40 → after the next boundary, `out_hi` = 0xFF for 128 cycles and 0x00 for 384 cycles, each 512-cycle period. duty 0x00 → constant 0x00; duty 0xFF → constant 0xFF.
- Stall: two back-to-back duty writes (0x80, 0x20) → second held with `wr_ready` = 0 until the first commits; then 0x20 commits one boundary later; no partial periods at either change.
- Bad address: write addr 0x05, data 0xFF → `err_addr` 1-cycle pulse; registers and pins unchanged.
- Boundary race: duty write accepted on the `wrap` cycle → the old duty persists one more full period, then the new duty applies.

Source files
------------

// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - register map and shared constants for the PWM register bank
package pwm_pkg;

   localparam logic [6:0] ADDR_EN_LO   = 7'h00;
   localparam logic [6:0] ADDR_EN_HI   = 7'h01;
   localparam logic [6:0] ADDR_MODE_LO = 7'h02;
   localparam logic [6:0] ADDR_MODE_HI = 7'h03;
   localparam logic [6:0] ADDR_DUTY    = 7'h04;

   localparam int MAX_ADDR = 4;
   localparam int DUTY_W   = 8;

   // Per-pin drive: disabled pins are low, enabled static pins high, enabled PWM pins follow pwm.
   function automatic logic [7:0] pin_drive(input logic [7:0] en,
                                            input logic [7:0] mode,
                                            input logic       pwm);
      return en & (~mode | {8{pwm}});
   endfunction

endpackage

// File: rtl/pwm_counter.sv
// rtl/pwm_counter.sv - prescaler, 8-bit PWM counter, period boundary and PWM waveform
module pwm_counter
   import pwm_pkg::*;
#(
   parameter int CLK_DIV = 12
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DUTY_W-1:0] duty_active_i,
   output logic              wrap_o,
   output logic              pwm_sig_o
);

   localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [PRE_W-1:0] pre_q, pre_d;
   logic [7:0]       cnt_q, cnt_d;
   logic             tick;

   // With CLK_DIV == 1 pre_q stays 0 and the compare is always true, so tick is constant 1.
   assign tick   = (pre_q == PRE_W'(CLK_DIV - 1));
   assign wrap_o = tick && (cnt_q == 8'hFF);

   // Full duty is special-cased so that 255 yields a constant high rather than 255/256.
   assign pwm_sig_o = (duty_active_i == 8'hFF) || (cnt_q < duty_active_i);

   // Next-state for prescaler and counter; the counter wraps 255 -> 0 naturally.
   always_comb begin
      pre_d = pre_q + PRE_W'(1);
      cnt_d = cnt_q;
      if (tick) begin
         pre_d = '0;
         cnt_d = cnt_q + 8'd1;
      end
   end

   // Prescaler and counter registers; reset restarts the period from zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_q <= '0;
         cnt_q <= '0;
      end else begin
         pre_q <= pre_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/pwm_register_bank.sv
// rtl/pwm_register_bank.sv - register file, shadowed duty commit, write handshake and pin drive
module pwm_register_bank #(
   parameter int CLK_DIV  = 12,
   parameter int MAX_ADDR = pwm_pkg::MAX_ADDR
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       wr_valid,
   input  logic [6:0] wr_addr,
   input  logic [7:0] wr_data,
   output logic       wr_ready,
   output logic [7:0] out_lo,
   output logic [7:0] out_hi,
   output logic       err_addr
);

   import pwm_pkg::*;

   logic [7:0]        en_lo_q, en_lo_d, en_hi_q, en_hi_d;
   logic [7:0]        mode_lo_q, mode_lo_d, mode_hi_q, mode_hi_d;
   logic [DUTY_W-1:0] duty_shadow_q, duty_shadow_d, duty_active_q, duty_active_d;
   logic              pend_q, pend_d;
   logic              err_q, err_d;
   logic [7:0]        out_lo_q, out_lo_d, out_hi_q, out_hi_d;
   logic              accept, bad_addr, wrap, pwm_sig;

   pwm_counter #(.CLK_DIV(CLK_DIV)) u_counter (
      .clk          (clk),
      .rst_n        (rst_n),
      .duty_active_i(duty_active_q),
      .wrap_o       (wrap),
      .pwm_sig_o    (pwm_sig)
   );

   // Stalling every address while a duty commit is pending keeps writes in order.
   assign wr_ready = !pend_q;
   assign accept   = wr_valid && !pend_q;
   assign bad_addr = (wr_addr > 7'(MAX_ADDR));

   assign out_lo   = out_lo_q;
   assign out_hi   = out_hi_q;
   assign err_addr = err_q;

   // Register decode, boundary commit of the shadow duty, and next pin values.
   always_comb begin
      en_lo_d       = en_lo_q;
      en_hi_d       = en_hi_q;
      mode_lo_d     = mode_lo_q;
      mode_hi_d     = mode_hi_q;
      duty_shadow_d = duty_shadow_q;
      duty_active_d = duty_active_q;
      pend_d        = pend_q;
      err_d         = accept && bad_addr;

      // A duty written on the wrap cycle itself only sees pend_q == 0 here, so it waits a period.
      if (wrap && pend_q) begin
         duty_active_d = duty_shadow_q;
         pend_d        = 1'b0;
      end

      if (accept && !bad_addr) begin
         case (wr_addr)
            ADDR_EN_LO:   en_lo_d   = wr_data;
            ADDR_EN_HI:   en_hi_d   = wr_data;
            ADDR_MODE_LO: mode_lo_d = wr_data;
            ADDR_MODE_HI: mode_hi_d = wr_data;
            ADDR_DUTY: begin
               duty_shadow_d = wr_data;
               pend_d        = 1'b1;
            end
            default: ;
         endcase
      end

      out_lo_d = pin_drive(en_lo_q, mode_lo_q, pwm_sig);
      out_hi_d = pin_drive(en_hi_q, mode_hi_q, pwm_sig);
   end

   // State registers; reset discards any pending duty and drives all pins low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_lo_q       <= '0;
         en_hi_q       <= '0;
         mode_lo_q     <= '0;
         mode_hi_q     <= '0;
         duty_shadow_q <= '0;
         duty_active_q <= '0;
         pend_q        <= 1'b0;
         err_q         <= 1'b0;
         out_lo_q      <= '0;
         out_hi_q      <= '0;
      end else begin
         en_lo_q       <= en_lo_d;
         en_hi_q       <= en_hi_d;
         mode_lo_q     <= mode_lo_d;
         mode_hi_q     <= mode_hi_d;
         duty_shadow_q <= duty_shadow_d;
         duty_active_q <= duty_active_d;
         pend_q        <= pend_d;
         err_q         <= err_d;
         out_lo_q      <= out_lo_d;
         out_hi_q      <= out_hi_d;
      end
   end

endmodule

// File: tb/tb_pwm_register_bank.sv
// tb/tb_pwm_register_bank.sv - randomized scoreboard bench for pwm_register_bank
module tb_pwm_register_bank;
   import pwm_pkg::*;

   localparam int CD = 2;
   localparam int P  = 256 * CD;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       wr_valid = 1'b0;
   logic [6:0] wr_addr = '0;
   logic [7:0] wr_data = '0;
   logic       wr_ready;
   logic [7:0] out_lo, out_hi;
   logic       err_addr;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   pwm_register_bank #(.CLK_DIV(CD), .MAX_ADDR(4)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_valid(wr_valid),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .wr_ready(wr_ready),
      .out_lo  (out_lo),
      .out_hi  (out_hi),
      .err_addr(err_addr)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference model: time since reset release gives the position within the period.
   int          m_t;
   logic [7:0]  m_en_lo, m_en_hi, m_mode_lo, m_mode_hi, m_sh, m_act;
   logic        m_pend, m_pwm, m_acc, m_err;
   int          m_cnt;
   logic [7:0]  m_lo, m_hi;
   logic [17:0] exp_q[$];

   initial begin
      forever begin
         @(posedge clk);
         if (!rst_n) begin
            m_t = 0; m_en_lo = 0; m_en_hi = 0; m_mode_lo = 0; m_mode_hi = 0;
            m_sh = 0; m_act = 0; m_pend = 0;
            exp_q.push_back({8'h00, 8'h00, 1'b1, 1'b0});
         end else begin
            m_cnt = (m_t / CD) % 256;
            m_pwm = (m_act == 8'd255) || (m_cnt < int'(m_act));
            for (int i = 0; i < 8; i++) begin
               m_lo[i] = m_en_lo[i] ? (m_mode_lo[i] ? m_pwm : 1'b1) : 1'b0;
               m_hi[i] = m_en_hi[i] ? (m_mode_hi[i] ? m_pwm : 1'b1) : 1'b0;
            end
            m_acc = wr_valid && !m_pend;
            if ((m_t % P) == P - 1 && m_pend) begin
               m_act  = m_sh;
               m_pend = 1'b0;
            end
            m_err = 1'b0;
            if (m_acc) begin
               if (int'(wr_addr) > 4) m_err = 1'b1;
               else if (wr_addr == 7'h00) m_en_lo = wr_data;
               else if (wr_addr == 7'h01) m_en_hi = wr_data;
               else if (wr_addr == 7'h02) m_mode_lo = wr_data;
               else if (wr_addr == 7'h03) m_mode_hi = wr_data;
               else begin m_sh = wr_data; m_pend = 1'b1; end
            end
            m_t++;
            exp_q.push_back({m_hi, m_lo, !m_pend, m_err});
         end
      end
   end

   // Monitor: compare every presented output cycle against the scoreboard.
   initial begin
      logic [17:0] e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("out_hi",   32'(out_hi),   32'(e[17:10]));
            check("out_lo",   32'(out_lo),   32'(e[9:2]));
            check("wr_ready", 32'(wr_ready), 32'(e[1]));
            check("err_addr", 32'(err_addr), 32'(e[0]));
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wr(input logic [6:0] a, input logic [7:0] d);
      int n = 0;
      wr_valid = 1'b1; wr_addr = a; wr_data = d;
      while (wr_ready !== 1'b1 && n < 2 * P + 10) begin @(negedge clk); n++; end
      if (n >= 2 * P + 10) check("wr_timeout_ready", 32'(wr_ready), 32'd1);
      @(negedge clk);
      wr_valid = 1'b0; wr_addr = 7'($urandom); wr_data = 8'($urandom);
   endtask

   task automatic wait_ready();
      int n = 0;
      while (wr_ready !== 1'b1 && n < 2 * P + 10) begin @(negedge clk); n++; end
      if (n >= 2 * P + 10) check("commit_timeout_ready", 32'(wr_ready), 32'd1);
   endtask

   task automatic measure(input string name, input int exp_hi);
      int hi = 0;
      repeat (P) begin @(negedge clk); if (out_hi == 8'hFF) hi++; end
      check(name, 32'(hi), 32'(exp_hi));
   endtask

   task automatic rand_writes(input int k);
      logic [6:0] a;
      for (int i = 0; i < k; i++) begin
         a = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(5, 127)) : 7'($urandom_range(0, 4));
         wr(a, 8'($urandom));
         idle($urandom_range(0, 4));
      end
   endtask

   initial begin
      int n;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      idle(4);

      wr(ADDR_EN_LO, 8'hA5);
      wr(ADDR_MODE_LO, 8'h00);
      idle(3);
      check("static_lo", 32'(out_lo), 32'hA5);
      check("static_hi", 32'(out_hi), 32'h00);

      wr(7'h05, 8'hFF);
      idle(3);
      check("badaddr_lo", 32'(out_lo), 32'hA5);

      wr(ADDR_EN_HI, 8'hFF);
      wr(ADDR_MODE_HI, 8'hFF);
      wr(ADDR_DUTY, 8'h40);
      wait_ready(); idle(2);
      measure("duty40_high", 128);
      wr(ADDR_DUTY, 8'h00);
      wait_ready(); idle(2);
      measure("duty00_high", 0);
      wr(ADDR_DUTY, 8'hFF);
      wait_ready(); idle(2);
      measure("dutyFF_high", P);

      wr(ADDR_DUTY, 8'h80);
      check("stall_ready", 32'(wr_ready), 32'd0);
      wr(ADDR_DUTY, 8'h20);
      wait_ready(); idle(2);
      measure("duty20_high", 64);

      wr(ADDR_DUTY, 8'h40);
      wait_ready();
      n = 0;
      while ((m_t % P) != P - 1 && n < 2 * P) begin @(negedge clk); n++; end
      wr(ADDR_DUTY, 8'hC0);
      measure("race_old_period", 128);
      wait_ready();
      measure("race_new_period", 384);

      rand_writes(40);

      wr(ADDR_DUTY, 8'h99);
      #1 rst_n = 1'b0;
      #1;
      check("rst_now_lo",  32'(out_lo),   32'h00);
      check("rst_now_hi",  32'(out_hi),   32'h00);
      check("rst_now_rdy", 32'(wr_ready), 32'd1);
      check("rst_now_err", 32'(err_addr), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      idle(10);
      check("rst_after_lo",  32'(out_lo),   32'h00);
      check("rst_after_hi",  32'(out_hi),   32'h00);
      check("rst_after_rdy", 32'(wr_ready), 32'd1);
      check("rst_after_err", 32'(err_addr), 32'd0);

      rand_writes(15);
      idle(4);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #3000000;
      n_fail++;
      $display("FAIL watchdog: simulation did not complete in time");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1);
   end

endmodule
